flash_cmd_responder: RTL and testbench

- Controller-side responder for the NAND flash command interface driven by the bench (clk, cmd, start, RWA, done).
- Accepts a start-qualified 3-bit command and a 16-bit row address (RWA), then sequences the NAND pin-level command, address and data cycles.
- Waits on ready/busy, reports completion on done, and reports erase status via EErr.
- Supports reset (011), erase block (100) and read ID (101). Page write/read (001/010) belong to a separate datapath block.

---
 rtl/flash_cmd_responder_if.sv | 32 +++
 rtl/flash_cmd_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_flash_cmd_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_cmd_responder_if.sv
// Host command port and NAND pin bus of the flash command responder.
// The master modport is the host/NAND-device side, the slave modport is the responder.
interface flash_cmd_responder_if;
    logic [2:0]  cmd;
    logic        start;
    logic [15:0] RWA;
    logic        done;
    logic        EErr;
    logic        cmd_err;
    logic [31:0] id_data;
    logic        nand_ce_n;
    logic        nand_cle;
    logic        nand_ale;
    logic        nand_we_n;
    logic        nand_re_n;
    logic [7:0]  nand_dout;
    logic        nand_doe;
    logic [7:0]  nand_din;
    logic        nand_rb_n;

    modport master (
        output cmd, start, RWA, nand_din, nand_rb_n,
        input  done, EErr, cmd_err, id_data,
        input  nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_re_n, nand_dout, nand_doe
    );

    modport slave (
        input  cmd, start, RWA, nand_din, nand_rb_n,
        output done, EErr, cmd_err, id_data,
        output nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_re_n, nand_dout, nand_doe
    );
endinterface

// File: rtl/flash_cmd_responder.sv
// NAND flash command sequencer: reset (FFh), block erase (60h/addr/D0h + status)
// and read ID (90h/00h + four bytes). Pin outputs are decoded from registers only.
module flash_cmd_responder #(
    parameter int PULSE        = 2,
    parameter int TWB          = 4,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    flash_cmd_responder_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WCMD, WADDR, WAIT_TWB, WAIT_RB, RDATA, FINISH} state_t;

    localparam logic [2:0]  OP_RESET   = 3'b011;
    localparam logic [2:0]  OP_ERASE   = 3'b100;
    localparam logic [2:0]  OP_RDID    = 3'b101;
    localparam logic [3:0]  PULSE_LAST = 4'(PULSE - 1);
    localparam logic [15:0] TWB_LAST   = 16'(TWB - 1);
    localparam logic [15:0] TO_LAST    = 16'(BUSY_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] rwa_q, rwa_d;
    logic [2:0]  step_q, step_d;      // position in the op's byte sequence / read index
    logic        phase_q, phase_d;    // 0: strobe low, 1: strobe high
    logic [3:0]  cnt_q, cnt_d;        // cycles within the current strobe phase
    logic [15:0] tmr_q, tmr_d;        // tWB and busy-wait cycle counter
    logic        done_q, done_d;
    logic        eerr_q, eerr_d;
    logic        cmd_err_q, cmd_err_d;
    logic [31:0] id_q, id_d;
    logic [7:0]  wr_byte;
    logic        pulse_last;

    // State and result registers; async reset returns everything to idle immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rwa_q     <= '0;
            step_q    <= '0;
            phase_q   <= 1'b0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            done_q    <= 1'b0;
            eerr_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rwa_q     <= rwa_d;
            step_q    <= step_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            done_q    <= done_d;
            eerr_q    <= eerr_d;
            cmd_err_q <= cmd_err_d;
            id_q      <= id_d;
        end
    end

    // Byte driven during the current write cycle, chosen by op and step
    always_comb begin
        wr_byte = 8'h00;
        case (op_q)
            OP_RESET: wr_byte = 8'hFF;
            OP_ERASE: begin
                case (step_q)
                    3'd0:    wr_byte = 8'h60;
                    3'd1:    wr_byte = rwa_q[7:0];
                    3'd2:    wr_byte = rwa_q[15:8];
                    3'd3:    wr_byte = 8'hD0;
                    default: wr_byte = 8'h70;
                endcase
            end
            OP_RDID:  wr_byte = (step_q == 3'd0) ? 8'h90 : 8'h00;
            default:  wr_byte = 8'h00;
        endcase
    end

    assign pulse_last = (cnt_q == PULSE_LAST);

    // Next-state sequencing; done/flags are set on the transition into FINISH
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rwa_d     = rwa_q;
        step_d    = step_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        done_d    = done_q;
        eerr_d    = eerr_q;
        cmd_err_d = cmd_err_q;
        id_d      = id_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.cmd)
                        OP_RESET, OP_ERASE, OP_RDID: begin
                            done_d    = 1'b0;
                            eerr_d    = 1'b0;
                            cmd_err_d = 1'b0;
                            op_d      = bus.cmd;
                            rwa_d     = bus.RWA;
                            step_d    = 3'd0;
                            phase_d   = 1'b0;
                            cnt_d     = '0;
                            state_d   = WCMD;
                        end
                        3'b001, 3'b010: begin
                            done_d    = 1'b1;
                            eerr_d    = 1'b0;
                            cmd_err_d = 1'b1;
                            op_d      = bus.cmd;
                            rwa_d     = bus.RWA;
                            state_d   = FINISH;
                        end
                        default: ;
                    endcase
                end
            end
            WCMD, WADDR: begin
                if (!pulse_last) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        tmr_d   = '0;
                        case (op_q)
                            OP_RESET: state_d = WAIT_TWB;
                            OP_ERASE: begin
                                step_d = step_q + 3'd1;
                                case (step_q)
                                    3'd0, 3'd1: state_d = WADDR;
                                    3'd2:       state_d = WCMD;
                                    3'd3:       state_d = WAIT_TWB;
                                    default:    state_d = RDATA;
                                endcase
                            end
                            OP_RDID: begin
                                step_d  = step_q + 3'd1;
                                state_d = (step_q == 3'd0) ? WADDR : WAIT_TWB;
                            end
                            default: begin
                                done_d  = 1'b1;
                                state_d = FINISH;
                            end
                        endcase
                    end
                end
            end
            WAIT_TWB: begin
                if (tmr_q == TWB_LAST) begin
                    tmr_d = '0;
                    if (op_q == OP_RDID) begin
                        step_d  = 3'd0;
                        state_d = RDATA;
                    end else begin
                        state_d = WAIT_RB;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            WAIT_RB: begin
                if (bus.nand_rb_n) begin
                    tmr_d = '0;
                    if (op_q == OP_ERASE) begin
                        step_d  = 3'd4;
                        state_d = WCMD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
                end else if (tmr_q == TO_LAST) begin
                    done_d    = 1'b1;
                    cmd_err_d = 1'b1;
                    eerr_d    = 1'b0;
                    state_d   = FINISH;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            RDATA: begin
                if (!pulse_last) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        if (op_q == OP_ERASE) eerr_d = bus.nand_din[0];
                        else                  id_d[{step_q[1:0], 3'b000} +: 8] = bus.nand_din;
                    end else begin
                        phase_d = 1'b0;
                        if (op_q == OP_RDID && step_q[1:0] != 2'd3) begin
                            step_d = step_q + 3'd1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = FINISH;
                        end
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin-level decode of the NAND bus from the registered state
    always_comb begin
        bus.nand_ce_n = 1'b1;
        bus.nand_cle  = 1'b0;
        bus.nand_ale  = 1'b0;
        bus.nand_we_n = 1'b1;
        bus.nand_re_n = 1'b1;
        bus.nand_dout = 8'h00;
        bus.nand_doe  = 1'b0;
        case (state_q)
            WCMD, WADDR: begin
                bus.nand_ce_n = 1'b0;
                bus.nand_doe  = 1'b1;
                bus.nand_dout = wr_byte;
                bus.nand_cle  = (state_q == WCMD);
                bus.nand_ale  = (state_q == WADDR);
                bus.nand_we_n = phase_q;
            end
            WAIT_TWB, WAIT_RB: bus.nand_ce_n = 1'b0;
            RDATA: begin
                bus.nand_ce_n = 1'b0;
                bus.nand_re_n = phase_q;
            end
            default: ;
        endcase
    end

    assign bus.done    = done_q;
    assign bus.EErr    = eerr_q;
    assign bus.cmd_err = cmd_err_q;
    assign bus.id_data = id_q;
endmodule

// File: tb/tb_flash_cmd_responder.sv
// Bench for flash_cmd_responder: a behavioural NAND device answers the bus, and each
// command's expected byte trace, flags and timing are derived from the command rules.
module tb_flash_cmd_responder;
    localparam int PULSE = 2;
    localparam int TWB   = 4;
    localparam int BTO   = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flash_cmd_responder_if bus();

    flash_cmd_responder #(.PULSE(PULSE), .TWB(TWB), .BUSY_TIMEOUT(BTO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // device configuration (written by the stimulus only)
    logic [7:0]  cfg_status = 8'h00;
    logic [31:0] cfg_id     = 32'h0;
    int          cfg_busy   = 10;

    // device/monitor state (written by the monitor only)
    logic [11:0] trace[$];
    int   bad_we = 0, bad_re = 0, bad_stable = 0, n_reads = 0;
    int   rise_cyc = 0, rb_rise_cyc = 0, busy_cnt = 0;
    int   we_low = 0, re_low = 0;
    logic prev_we = 1'b1, prev_re = 1'b1, rd_status = 1'b0;
    logic [1:0]  rd_idx = 2'd0;
    logic [11:0] fall_snap = 12'h0;

    function automatic logic [11:0] snap();
        return {bus.nand_ce_n, bus.nand_doe, bus.nand_cle, bus.nand_ale, bus.nand_dout};
    endfunction

    function automatic logic [11:0] wr(input logic cle, input logic [7:0] b);
        return {1'b0, 1'b1, cle, ~cle, b};
    endfunction

    // NAND device model: logs write cycles, drives busy and read data
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            bus.nand_rb_n = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                bus.nand_rb_n = 1'b1;
                rb_rise_cyc = cyc;
            end
        end
        if (bus.nand_we_n == 1'b0) begin
            if (prev_we) fall_snap = snap();
            else if (snap() != fall_snap) bad_stable++;
            we_low++;
        end else if (prev_we == 1'b0) begin
            if (we_low != PULSE) bad_we++;
            we_low = 0;
            trace.push_back(fall_snap);
            rise_cyc = cyc;
            if (fall_snap[9] && (fall_snap[7:0] == 8'hFF || fall_snap[7:0] == 8'hD0)) begin
                busy_cnt = cfg_busy;
                bus.nand_rb_n = 1'b0;
            end
            if (fall_snap[9] && fall_snap[7:0] == 8'h70) rd_status = 1'b1;
            if (fall_snap[9] && fall_snap[7:0] == 8'h90) begin
                rd_status = 1'b0;
                rd_idx = 2'd0;
            end
        end
        prev_we = bus.nand_we_n;
        if (bus.nand_re_n == 1'b0) begin
            if (prev_re) begin
                bus.nand_din = rd_status ? cfg_status : cfg_id[{rd_idx, 3'b000} +: 8];
                rd_idx = rd_idx + 2'd1;
            end
            re_low++;
        end else if (prev_re == 1'b0) begin
            if (re_low != PULSE) bad_re++;
            re_low = 0;
            n_reads++;
        end
        prev_re = bus.nand_re_n;
    end

    logic [31:0] exp_id = 32'h0;

    task automatic run_op(input logic [2:0] c, input logic [15:0] rwa, input logic [7:0] st,
                          input logic [31:0] idb, input int busy, input bit hang, input bit inject);
        logic [11:0] exp_q[$];
        int  base, bwe, bre, bst, bnr, done_cyc, exp_reads;
        bit  got_done, timeout;
        logic exp_eerr, exp_cerr;
        timeout    = hang && (c == 3'b100 || c == 3'b011);
        cfg_status = st;
        cfg_id     = idb;
        cfg_busy   = hang ? 100000 : busy;
        exp_q      = {};
        exp_reads  = 0;
        case (c)
            3'b011: exp_q = {wr(1, 8'hFF)};
            3'b100: begin
                exp_q = {wr(1, 8'h60), wr(0, rwa[7:0]), wr(0, rwa[15:8]), wr(1, 8'hD0)};
                if (!timeout) begin
                    exp_q.push_back(wr(1, 8'h70));
                    exp_reads = 1;
                end
            end
            3'b101: begin
                exp_q = {wr(1, 8'h90), wr(0, 8'h00)};
                exp_reads = 4;
            end
            default: ;
        endcase
        exp_eerr = (c == 3'b100) && !timeout && st[0];
        exp_cerr = (c == 3'b001 || c == 3'b010) || timeout;
        if (c == 3'b101) exp_id = idb;
        base = trace.size(); bwe = bad_we; bre = bad_re; bst = bad_stable; bnr = n_reads;
        done_cyc = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.cmd = c; bus.RWA = rwa;
        @(negedge clk);
        bus.start = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (bus.done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (inject && i == 4) begin
                bus.start = 1'b1; bus.cmd = 3'b101; bus.RWA = ~rwa;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("done", 32'(got_done), 32'd1);
        check("EErr", 32'(bus.EErr), 32'(exp_eerr));
        check("cmd_err", 32'(bus.cmd_err), 32'(exp_cerr));
        check("id_data", bus.id_data, exp_id);
        check("trace_len", 32'(trace.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < trace.size(); i++)
            check("trace_byte", 32'(trace[base + i]), 32'(exp_q[i]));
        check("read_cycles", 32'(n_reads - bnr), 32'(exp_reads));
        check("we_low_len", 32'(bad_we - bwe), 32'd0);
        check("re_low_len", 32'(bad_re - bre), 32'd0);
        check("wr_stable", 32'(bad_stable - bst), 32'd0);
        if (c == 3'b011 && !timeout)
            check("rb_to_done", 32'((done_cyc - rb_rise_cyc) <= 2 && done_cyc > rb_rise_cyc), 32'd1);
        if (timeout) begin
            check("timeout_bound", 32'((done_cyc - (rise_cyc + PULSE)) <= BTO + TWB), 32'd1);
            check("timeout_waited", 32'((done_cyc - rise_cyc) >= BTO), 32'd1);
        end
        @(negedge clk);
        check("done_hold", 32'(bus.done), 32'd1);
    endtask

    task automatic nop_check();
        int base;
        logic keep_cerr;
        base = trace.size();
        keep_cerr = bus.cmd_err;
        @(negedge clk);
        bus.start = 1'b1; bus.cmd = 3'b000; bus.RWA = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("nop_done", 32'(bus.done), 32'd1);
        check("nop_cmd_err", 32'(bus.cmd_err), 32'(keep_cerr));
        check("nop_bus", 32'(trace.size() - base), 32'd0);
        check("nop_ce_n", 32'(bus.nand_ce_n), 32'd1);
    endtask

    task automatic midop_reset();
        bit found;
        @(negedge clk);
        bus.start = 1'b1; bus.cmd = 3'b100; bus.RWA = 16'h5AA5;
        @(negedge clk);
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.nand_ale && !bus.nand_we_n) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_addr_cycle", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_ce_n", 32'(bus.nand_ce_n), 32'd1);
        check("rst_we_n", 32'(bus.nand_we_n), 32'd1);
        check("rst_doe", 32'(bus.nand_doe), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_id", bus.id_data, 32'h0);
        exp_id = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(bus.nand_ce_n), 32'd1);
    endtask

    initial begin
        logic [2:0] cmds [5];
        logic [2:0] c;
        cmds[0] = 3'b011; cmds[1] = 3'b100; cmds[2] = 3'b101; cmds[3] = 3'b001; cmds[4] = 3'b010;
        bus.start = 1'b0; bus.cmd = 3'b000; bus.RWA = 16'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_EErr", 32'(bus.EErr), 32'd0);
        check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        check("rst_id_data", bus.id_data, 32'h0);
        check("rst_pins", {20'h0, bus.nand_ce_n, bus.nand_cle, bus.nand_ale, bus.nand_we_n,
                           bus.nand_re_n, bus.nand_doe, bus.nand_dout == 8'h00, 5'h0},
              {20'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'h0});
        rst = 1'b0;
        @(negedge clk);

        run_op(3'b011, 16'h0000, 8'h00, 32'h0, 20, 0, 0);           // reset command
        run_op(3'b100, 16'h1A2B, 8'hE0, 32'h0, 30, 0, 0);           // erase pass
        run_op(3'b100, 16'h1A2B, 8'hE1, 32'h0, 30, 0, 0);           // erase fail
        run_op(3'b101, 16'h0000, 8'h00, 32'h9500F1EC, 0, 0, 0);     // read ID
        run_op(3'b100, 16'h3C4D, 8'hE1, 32'h0, 0, 1, 0);            // busy timeout
        run_op(3'b101, 16'h0000, 8'h00, 32'h12345678, 0, 0, 0);     // read ID with rb_n stuck low
        run_op(3'b100, 16'hBEEF, 8'hE1, 32'h0, 25, 0, 1);           // second start ignored
        run_op(3'b001, 16'h0000, 8'h00, 32'h0, 0, 0, 0);            // unsupported
        nop_check();
        run_op(3'b010, 16'h0000, 8'h00, 32'h0, 0, 0, 0);            // unsupported
        midop_reset();

        for (int n = 0; n < 12; n++) begin
            c = cmds[$urandom_range(0, 4)];
            run_op(c, 16'($urandom), 8'($urandom), $urandom, int'($urandom_range(10, 60)), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
